uart_tx: RTL

- 8N1 UART transmit serializer sitting directly downstream of the transmit fifo.
- Pops one byte from the fifo whenever the fifo is non-empty and the line is idle, then shifts it out on tx: start bit, 8 data bits LSB first, one stop bit.
- Baud timing comes from an internal clock divider.
- No parity and no flow control in this block.

---
 rtl/uart_tx.sv | 73 +++++++
 1 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serializer that pops bytes from a fifo and shifts them out LSB first with an internal baud divider
module uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_WIDTH    = $clog2(CLKS_PER_BIT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tx_en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_rd_en,
  output logic             tx,
  output logic             busy,
  output logic             tx_done
);
  localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;
  state_t state, state_nx;
  logic [CNT_WIDTH-1:0] baud_cnt, baud_nx;
  logic [IW-1:0] bit_idx, idx_nx;
  logic [WIDTH-1:0] shift, shift_nx;
  logic baud_tc, last, tx_nx;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      state    <= state_nx;
      tx       <= tx_nx;
      baud_cnt <= baud_nx;
      bit_idx  <= idx_nx;
      shift    <= shift_nx;
    end
  end
  always_comb begin
    fifo_rd_en = (state == IDLE) & tx_en & ~fifo_empty & rst_n;
    busy       = state != IDLE;
    baud_tc    = baud_cnt == CNT_WIDTH'(CLKS_PER_BIT - 1);
    last       = bit_idx == IW'(WIDTH - 1);
    tx_done    = (state == STOP) & baud_tc;
    state_nx   = state;
    baud_nx    = baud_tc ? '0 : baud_cnt + 1'b1;
    idx_nx     = bit_idx;
    shift_nx   = shift;
    case (state)
      IDLE: begin
        state_nx = fifo_rd_en ? LOAD : IDLE;
        baud_nx  = '0;
      end
      LOAD: begin
        state_nx = START;
        shift_nx = fifo_data;
        baud_nx  = '0;
      end
      START: if (baud_tc) begin
        state_nx = DATA;
        idx_nx   = '0;
      end
      DATA: if (baud_tc) begin
        shift_nx = shift >> 1;
        idx_nx   = last ? '0 : bit_idx + 1'b1;
        state_nx = last ? STOP : DATA;
      end
      STOP: if (baud_tc) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    tx_nx = state_nx == START ? 1'b0 : state_nx == DATA ? shift_nx[0] : 1'b1;
  end
endmodule
